// File: rtl/advtim_break_monitor.sv
// Break / fault monitor for the advanced timer.
// Each break channel runs through a synchroniser, a polarity adjust and a digital glitch filter.
// The qualified breaks, the system-failure line and the software break drive sticky flags and a
// latch / auto-recovery FSM that requests PWM shutdown.
module advtim_break_monitor #(
    parameter int unsigned NUM_BK      = 2,
    parameter int unsigned FLT_W       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    pe_fault_clk,
    input  logic                    pe_fault_rstn,
    input  logic [NUM_BK-1:0]       r_bke,
    input  logic [NUM_BK-1:0]       r_bkp,
    input  logic [NUM_BK*FLT_W-1:0] r_bkf,
    input  logic                    r_aoe,
    input  logic [NUM_BK-1:0]       advtmr_bk,
    input  logic                    system_failure,
    input  logic                    sw_bg,
    input  logic [NUM_BK:0]         sw_flag_clr,
    input  logic                    sw_fault_clr,
    input  logic                    update_event,
    output logic [NUM_BK-1:0]       bk_flag,
    output logic                    sf_flag,
    output logic                    fault_detected,
    output logic                    fault_irq
);

    typedef enum logic [1:0] {
        StArmed   = 2'd0,
        StFault   = 2'd1,
        StWaitUpd = 2'd2
    } state_e;

    logic [NUM_BK-1:0] qual_q, qual_d;
    logic [NUM_BK-1:0] bk_flag_q, bk_flag_d;
    logic              qual_sf_q, qual_sw_q;
    logic              sf_flag_q, sf_flag_d;
    logic              any_qual;
    state_e            state_q, state_d;
    logic              fault_q, fault_d;
    logic              irq_q, irq_d;

    for (genvar i = 0; i < NUM_BK; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [FLT_W-1:0]       cnt_q, cnt_d;
        logic [FLT_W-1:0]       bkf;
        logic [FLT_W-1:0]       neff_m1;
        logic                   active;

        // Break pin synchroniser chain.
        always_ff @(posedge pe_fault_clk or negedge pe_fault_rstn) begin
            if (!pe_fault_rstn) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], advtmr_bk[i]};
            end
        end

        // Polarity adjust, saturating filter count and qualification decision.
        always_comb begin
            bkf     = r_bkf[i*FLT_W +: FLT_W];
            // A zero filter length behaves like a length of one.
            neff_m1 = (bkf == '0) ? '0 : bkf - FLT_W'(1);
            active  = sync_q[SYNC_STAGES-1] ^ ~r_bkp[i];
            cnt_d   = '0;
            if (active && r_bke[i]) begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + FLT_W'(1);
            end
            // Compared live, so a shrunk length can qualify immediately.
            qual_d[i] = active && r_bke[i] && (cnt_q >= neff_m1);
        end

        // Filter counter register.
        always_ff @(posedge pe_fault_clk or negedge pe_fault_rstn) begin
            if (!pe_fault_rstn) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Qualified-event registers for the break channels, system failure and software break.
    always_ff @(posedge pe_fault_clk or negedge pe_fault_rstn) begin
        if (!pe_fault_rstn) begin
            qual_q    <= '0;
            qual_sf_q <= 1'b0;
            qual_sw_q <= 1'b0;
        end else begin
            qual_q    <= qual_d;
            qual_sf_q <= system_failure;
            qual_sw_q <= sw_bg;
        end
    end

    // Sticky flags: set on a qualification rising edge, set wins over a same-cycle clear.
    always_comb begin
        bk_flag_d = (qual_d & ~qual_q) | (bk_flag_q & ~sw_flag_clr[NUM_BK-1:0]);
        sf_flag_d = (system_failure & ~qual_sf_q) | (sf_flag_q & ~sw_flag_clr[NUM_BK]);
    end

    // Flag registers.
    always_ff @(posedge pe_fault_clk or negedge pe_fault_rstn) begin
        if (!pe_fault_rstn) begin
            bk_flag_q <= '0;
            sf_flag_q <= 1'b0;
        end else begin
            bk_flag_q <= bk_flag_d;
            sf_flag_q <= sf_flag_d;
        end
    end

    assign any_qual = (|qual_q) | qual_sf_q | qual_sw_q;

    // Fault FSM next state; shutdown and irq are registered off the next state.
    always_comb begin
        state_d = state_q;
        irq_d   = 1'b0;
        unique case (state_q)
            StArmed: begin
                if (any_qual) begin
                    state_d = StFault;
                    irq_d   = 1'b1;
                end
            end
            StFault: begin
                if (!any_qual) begin
                    if (r_aoe) begin
                        state_d = StWaitUpd;
                    end else if (sw_fault_clr) begin
                        state_d = StArmed;
                    end
                end
            end
            StWaitUpd: begin
                // Stays here until an update even if auto-recovery is turned off meanwhile.
                if (any_qual) begin
                    state_d = StFault;
                end else if (update_event) begin
                    state_d = StArmed;
                end
            end
            default: state_d = StArmed;
        endcase
        fault_d = (state_d != StArmed);
    end

    // FSM state, shutdown request and interrupt registers.
    always_ff @(posedge pe_fault_clk or negedge pe_fault_rstn) begin
        if (!pe_fault_rstn) begin
            state_q <= StArmed;
            fault_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            irq_q   <= irq_d;
        end
    end

    assign bk_flag        = bk_flag_q;
    assign sf_flag        = sf_flag_q;
    assign fault_detected = fault_q;
    assign fault_irq      = irq_q;

endmodule

// File: tb/tb_advtim_break_monitor.sv
// Directed bench for advtim_break_monitor (NUM_BK=2, FLT_W=4, SYNC_STAGES=2).
module tb_advtim_break_monitor;

    logic       clk;
    logic       rstn;
    logic [1:0] r_bke;
    logic [1:0] r_bkp;
    logic [7:0] r_bkf;
    logic       r_aoe;
    logic [1:0] advtmr_bk;
    logic       system_failure;
    logic       sw_bg;
    logic [2:0] sw_flag_clr;
    logic       sw_fault_clr;
    logic       update_event;
    logic [1:0] bk_flag;
    logic       sf_flag;
    logic       fault_detected;
    logic       fault_irq;

    int checks;
    int errors;
    int irq_cnt;

    advtim_break_monitor #(
        .NUM_BK      (2),
        .FLT_W       (4),
        .SYNC_STAGES (2)
    ) dut (
        .pe_fault_clk   (clk),
        .pe_fault_rstn  (rstn),
        .r_bke          (r_bke),
        .r_bkp          (r_bkp),
        .r_bkf          (r_bkf),
        .r_aoe          (r_aoe),
        .advtmr_bk      (advtmr_bk),
        .system_failure (system_failure),
        .sw_bg          (sw_bg),
        .sw_flag_clr    (sw_flag_clr),
        .sw_fault_clr   (sw_fault_clr),
        .update_event   (update_event),
        .bk_flag        (bk_flag),
        .sf_flag        (sf_flag),
        .fault_detected (fault_detected),
        .fault_irq      (fault_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One active edge, then settle 1 time unit so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rstn           = 1'b0;
        r_bke          = 2'b01;
        r_bkp          = 2'b01;
        r_bkf          = 8'h03;
        r_aoe          = 1'b0;
        advtmr_bk      = 2'b10;
        system_failure = 1'b0;
        sw_bg          = 1'b0;
        sw_flag_clr    = 3'b000;
        sw_fault_clr   = 1'b0;
        update_event   = 1'b0;

        tick();
        check_eq("rst_bk_flag", 32'(bk_flag), 32'd0);
        check_eq("rst_sf_flag", 32'(sf_flag), 32'd0);
        check_eq("rst_fault", 32'(fault_detected), 32'd0);
        check_eq("rst_irq", 32'(fault_irq), 32'd0);
        rstn = 1'b1;
        repeat (3) tick();

        // 2-cycle glitch against a filter length of 3: must be swallowed.
        advtmr_bk[0] = 1'b1;
        tick();
        tick();
        advtmr_bk[0] = 1'b0;
        irq_cnt = 0;
        repeat (8) begin
            tick();
            irq_cnt += int'(fault_irq);
        end
        check_eq("glitch_flag", 32'(bk_flag), 32'd0);
        check_eq("glitch_fault", 32'(fault_detected), 32'd0);
        check_eq("glitch_irq", 32'(irq_cnt), 32'd0);

        // 5-cycle pulse: flag after 5 edges, shutdown after 6, single irq.
        advtmr_bk[0] = 1'b1;
        repeat (4) tick();
        check_eq("pulse_flag_early", 32'(bk_flag), 32'd0);
        tick();
        check_eq("pulse_flag", 32'(bk_flag), 32'd1);
        check_eq("pulse_fault_early", 32'(fault_detected), 32'd0);
        advtmr_bk[0] = 1'b0;
        tick();
        check_eq("pulse_fault", 32'(fault_detected), 32'd1);
        check_eq("pulse_irq", 32'(fault_irq), 32'd1);
        tick();
        check_eq("pulse_irq_single", 32'(fault_irq), 32'd0);
        repeat (4) tick();

        // Latched mode: manual clear ignored while break active; update never clears.
        advtmr_bk[0] = 1'b1;
        repeat (6) tick();
        sw_fault_clr = 1'b1;
        tick();
        sw_fault_clr = 1'b0;
        check_eq("clr_while_active", 32'(fault_detected), 32'd1);
        update_event = 1'b1;
        tick();
        update_event = 1'b0;
        check_eq("upd_while_active", 32'(fault_detected), 32'd1);
        advtmr_bk[0] = 1'b0;
        repeat (5) tick();
        check_eq("latched_hold", 32'(fault_detected), 32'd1);
        update_event = 1'b1;
        tick();
        update_event = 1'b0;
        check_eq("upd_no_clear", 32'(fault_detected), 32'd1);
        sw_fault_clr = 1'b1;
        tick();
        sw_fault_clr = 1'b0;
        check_eq("manual_rearm", 32'(fault_detected), 32'd0);
        sw_flag_clr = 3'b001;
        tick();
        sw_flag_clr = 3'b000;
        check_eq("bk0_flag_clr", 32'(bk_flag), 32'd0);

        // Active-low channel 1 with filter length 0: flag after 3 edges.
        r_bke = 2'b11;
        advtmr_bk[1] = 1'b0;
        tick();
        tick();
        check_eq("ch1_flag_early", 32'(bk_flag), 32'd0);
        tick();
        check_eq("ch1_flag", 32'(bk_flag), 32'd2);
        tick();
        check_eq("ch1_fault", 32'(fault_detected), 32'd1);
        advtmr_bk[1] = 1'b1;
        repeat (4) tick();
        sw_fault_clr = 1'b1;
        sw_flag_clr  = 3'b010;
        tick();
        sw_fault_clr = 1'b0;
        sw_flag_clr  = 3'b000;
        check_eq("ch1_rearm", 32'(fault_detected), 32'd0);
        check_eq("ch1_flag_clr", 32'(bk_flag), 32'd0);

        // Same stimulus with channel 1 disabled: no response.
        r_bke = 2'b01;
        advtmr_bk[1] = 1'b0;
        repeat (8) tick();
        check_eq("ch1_dis_flag", 32'(bk_flag), 32'd0);
        check_eq("ch1_dis_fault", 32'(fault_detected), 32'd0);
        advtmr_bk[1] = 1'b1;
        repeat (3) tick();

        // Auto-recovery: hold through WAIT_UPD, re-break without irq, update clears.
        r_aoe = 1'b1;
        advtmr_bk[0] = 1'b1;
        repeat (6) tick();
        check_eq("aoe_fault", 32'(fault_detected), 32'd1);
        check_eq("aoe_irq", 32'(fault_irq), 32'd1);
        advtmr_bk[0] = 1'b0;
        irq_cnt = 0;
        repeat (8) begin
            tick();
            irq_cnt += int'(fault_irq);
        end
        check_eq("wait_upd_hold", 32'(fault_detected), 32'd1);
        sw_bg = 1'b1;
        tick();
        sw_bg = 1'b0;
        repeat (4) begin
            tick();
            irq_cnt += int'(fault_irq);
        end
        check_eq("rebreak_no_irq", 32'(irq_cnt), 32'd0);
        check_eq("rebreak_fault", 32'(fault_detected), 32'd1);
        update_event = 1'b1;
        tick();
        update_event = 1'b0;
        check_eq("upd_recover", 32'(fault_detected), 32'd0);

        // System failure: flag after one edge, shutdown after two.
        r_aoe = 1'b0;
        system_failure = 1'b1;
        tick();
        system_failure = 1'b0;
        check_eq("sf_flag_set", 32'(sf_flag), 32'd1);
        check_eq("sf_fault_early", 32'(fault_detected), 32'd0);
        tick();
        check_eq("sf_fault", 32'(fault_detected), 32'd1);
        check_eq("sf_irq", 32'(fault_irq), 32'd1);
        sw_flag_clr = 3'b100;
        tick();
        sw_flag_clr = 3'b000;
        check_eq("sf_flag_clr", 32'(sf_flag), 32'd0);
        system_failure = 1'b1;
        sw_flag_clr    = 3'b100;
        tick();
        system_failure = 1'b0;
        sw_flag_clr    = 3'b000;
        check_eq("sf_set_wins", 32'(sf_flag), 32'd1);
        tick();
        check_eq("sf_sticky", 32'(sf_flag), 32'd1);

        // Asynchronous reset in FAULT with flags set.
        rstn = 1'b0;
        #2;
        check_eq("arst_bk_flag", 32'(bk_flag), 32'd0);
        check_eq("arst_sf_flag", 32'(sf_flag), 32'd0);
        check_eq("arst_fault", 32'(fault_detected), 32'd0);
        check_eq("arst_irq", 32'(fault_irq), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check_eq("post_rst_fault", 32'(fault_detected), 32'd0);
        sw_bg = 1'b1;
        tick();
        sw_bg = 1'b0;
        check_eq("sw_bg_fault_early", 32'(fault_detected), 32'd0);
        tick();
        check_eq("post_rst_armed", 32'(fault_detected), 32'd1);
        check_eq("post_rst_irq", 32'(fault_irq), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
